// File: rtl/seg_scan_controller.sv
// Multiplexed 4-digit 7-seg scan; outputs registered (1 clk after slot timer), value swap only at frame end.
// Backpressure: wr_ready drops while a value is pending and returns the cycle after the frame boundary applies it.
module seg_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int LZ_BLANK     = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_valid,
    input  logic [4*NUM_DIGITS-1:0] wr_data,
    output logic                    wr_ready,
    output logic [3:0]              digit,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_ON    = 1'b1;

    logic [CNT_W-1:0]        slot_q, slot_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [0:0]              state_q, state_d;
    logic [4*NUM_DIGITS-1:0] active_q, active_d;
    logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
    logic                    pend_vld_q, pend_vld_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [3:0]              digit_q, digit_d;
    logic                    fd_q, fd_d;

    logic                    last_slot;
    logic                    boundary;
    logic                    wr_fire;
    logic                    zero_run;
    logic [3:0]              nib;
    logic [3:0]              sel_nib;

    always_comb begin
        last_slot = (slot_q == LAST_CNT);
        boundary  = last_slot && (idx_q == LAST_IDX);
        wr_fire   = wr_valid && !pend_vld_q;

        slot_d = last_slot ? '0 : slot_q + CNT_W'(1);
        idx_d  = idx_q;
        if (last_slot) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end

        state_d = state_q;
        if (slot_q == BLANK_LAST) begin
            state_d = ST_ON;
        end else if (last_slot) begin
            state_d = ST_BLANK;
        end

        active_d   = active_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        if (boundary && pend_vld_q) begin
            active_d   = pend_q;
            pend_vld_d = 1'b0;
        end
        if (wr_fire) begin
            pend_d     = wr_data;
            pend_vld_d = 1'b1;
        end

        // Walk from the most significant digit down; zero_run stays set while every nibble so far is 0.
        zero_run = 1'b1;
        nib      = 4'h0;
        sel_nib  = 4'hF;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nib      = active_q[4*i +: 4];
            zero_run = zero_run && (nib == 4'h0);
            if (idx_d == IDX_W'(i)) begin
                sel_nib = (zero_run && (i != 0) && (LZ_BLANK != 0)) ? 4'hF : nib;
            end
        end

        an_d    = '1;
        digit_d = 4'hF;
        if (state_d == ST_ON) begin
            an_d    = ~(NUM_DIGITS'(1) << idx_d);
            digit_d = sel_nib;
        end

        fd_d = (slot_d == LAST_CNT) && (idx_d == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q     <= '0;
            idx_q      <= '0;
            state_q    <= ST_BLANK;
            active_q   <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            an_q       <= '1;
            digit_q    <= 4'hF;
            fd_q       <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            idx_q      <= idx_d;
            state_q    <= state_d;
            active_q   <= active_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            an_q       <= an_d;
            digit_q    <= digit_d;
            fd_q       <= fd_d;
        end
    end

    assign wr_ready   = ~pend_vld_q;
    assign an         = an_q;
    assign digit      = digit_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench: two controllers (leading-zero blanking off/on) share stimulus; each ON slot is
// checked against expectations queued when the corresponding value was written.
module tb_seg_scan_controller;

    logic        clk;
    logic        rst;
    logic        wr_valid;
    logic [15:0] wr_data;
    logic        rdy0, rdy1;
    logic [3:0]  dig0, dig1;
    logic [3:0]  an0, an1;
    logic        fd0, fd1;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    logic [11:0] exp_q[$];

    seg_scan_controller #(.NUM_DIGITS(4), .PRESCALE(8), .BLANK_CYCLES(2), .LZ_BLANK(0)) dut_lz0 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(rdy0),
        .digit(dig0), .an(an0), .frame_done(fd0)
    );

    seg_scan_controller #(.NUM_DIGITS(4), .PRESCALE(8), .BLANK_CYCLES(2), .LZ_BLANK(1)) dut_lz1 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(rdy1),
        .digit(dig1), .an(an1), .frame_done(fd1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [3:0] exp_dig(input logic [15:0] v, input int i, input bit lz);
        logic [15:0] hi;
        hi = v >> (4 * i);
        if (lz && i != 0 && hi == 16'h0) return 4'hF;
        return hi[3:0];
    endfunction

    task automatic push_frame(input logic [15:0] v);
        for (int i = 0; i < 4; i++) begin
            logic [3:0] a;
            a    = 4'b1111;
            a[i] = 1'b0;
            exp_q.push_back({a, exp_dig(v, i, 1'b0), exp_dig(v, i, 1'b1)});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fd(output int t);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            tick();
            if (fd0) got = 1'b1;
        end
        check("frame_done_seen", {31'd0, got}, 32'd1);
        check("frame_done_match", {31'd0, fd1}, {31'd0, fd0});
        t = cyc;
    endtask

    task automatic do_write(input logic [15:0] v);
        check("wr_ready_before", {30'd0, rdy1, rdy0}, 32'd3);
        wr_valid = 1'b1;
        wr_data  = v;
        tick();
        wr_valid = 1'b0;
        check("wr_ready_after", {30'd0, rdy1, rdy0}, 32'd0);
    endtask

    // Slot monitor: the first ON sample of each slot pops one expectation.
    initial begin
        logic [3:0]  prev_an;
        logic [11:0] e;
        prev_an = 4'hF;
        forever begin
            @(negedge clk);
            if (!rst && an0 != 4'hF && prev_an == 4'hF && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("slot_an_lz0",  {28'd0, an0},  {28'd0, e[11:8]});
                check("slot_an_lz1",  {28'd0, an1},  {28'd0, e[11:8]});
                check("slot_dig_lz0", {28'd0, dig0}, {28'd0, e[7:4]});
                check("slot_dig_lz1", {28'd0, dig1}, {28'd0, e[3:0]});
            end
            prev_an = an0;
        end
    end

    initial begin
        int t0, t1, t2;
        bit got;
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_data  = 16'h0;

        // Reset state
        repeat (3) tick();
        check("rst_an",       {24'd0, an1, an0}, 32'hFF);
        check("rst_digit",    {24'd0, dig1, dig0}, 32'hFF);
        check("rst_wr_ready", {30'd0, rdy1, rdy0}, 32'd3);
        check("rst_fd",       {30'd0, fd1, fd0}, 32'd0);
        push_frame(16'h0000);
        rst = 1'b0;
        tick();
        check("post_rst_blank_an", {28'd0, an0}, 32'hF);
        tick();
        check("first_on_an",    {24'd0, an1, an0}, 32'hEE);
        check("first_on_digit", {24'd0, dig1, dig0}, 32'h00);

        // Scan order: a write on the boundary cycle waits a full frame
        wait_fd(t0);
        push_frame(16'h0000);
        do_write(16'h1234);
        wait_fd(t1);
        check("frame_period_1", t1 - t0, 32);
        check("wr_ready_at_apply", {31'd0, rdy0}, 32'd0);
        push_frame(16'h1234);
        wait_fd(t2);
        check("frame_period_2", t2 - t1, 32);
        check("wr_ready_after_apply", {31'd0, rdy0}, 32'd1);

        // Tear-free update plus a held write under backpressure
        push_frame(16'h1234);
        repeat (10) tick();
        do_write(16'h5678);
        wr_valid = 1'b1;
        wr_data  = 16'h9999;
        repeat (3) tick();
        check("bp_ready_low", {30'd0, rdy1, rdy0}, 32'd0);
        wait_fd(t0);
        check("frame_period_3", t0 - t2, 32);
        check("bp_ready_low_boundary", {31'd0, rdy0}, 32'd0);
        push_frame(16'h5678);
        tick();
        check("bp_ready_returns", {31'd0, rdy0}, 32'd1);
        tick();
        wr_valid = 1'b0;
        check("bp_held_accepted", {31'd0, rdy0}, 32'd0);
        wait_fd(t1);
        push_frame(16'h9999);

        // Leading zeros
        tick();
        do_write(16'h0042);
        wait_fd(t1);
        push_frame(16'h0042);
        tick();
        do_write(16'h0000);
        wait_fd(t1);
        push_frame(16'h0000);
        tick();
        do_write(16'h0A00);
        wait_fd(t1);
        push_frame(16'h0A00);
        wait_fd(t1);

        // Reset during digit 2 ON slot with a write pending
        tick();
        do_write(16'h7777);
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            tick();
            if (an0 == 4'b1011) got = 1'b1;
        end
        check("digit2_slot_seen", {31'd0, got}, 32'd1);
        rst = 1'b1;
        tick();
        check("midrst_an",       {24'd0, an1, an0}, 32'hFF);
        check("midrst_digit",    {24'd0, dig1, dig0}, 32'hFF);
        check("midrst_wr_ready", {30'd0, rdy1, rdy0}, 32'd3);
        check("midrst_fd",       {30'd0, fd1, fd0}, 32'd0);
        push_frame(16'h0000);
        push_frame(16'h0000);
        rst = 1'b0;
        wait_fd(t0);
        wait_fd(t1);
        check("midrst_period", t1 - t0, 32);

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
